// File: rtl/r5p_pkg.sv
// Shared types for the r5p write-back path: load size encoding and the record
// kept for the single outstanding load.
package r5p_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_siz_t;

  // Field widths cover the largest configuration (AW=5, XLEN=64).
  localparam int unsigned RD_W  = 5;
  localparam int unsigned OFF_W = 3;

  typedef struct packed {
    logic [RD_W-1:0]  rd;
    ld_siz_t          siz;
    logic             uns;
    logic [OFF_W-1:0] off;
  } ld_pend_t;

endpackage

// File: rtl/r5p_wbu_lda.sv
// Load data aligner: shifts raw bus data down by the byte offset, truncates to
// the access size and sign- or zero-extends to XLEN.
module r5p_wbu_lda
  import r5p_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]  rdt_i,
  input  logic [1:0]       siz_i,
  input  logic             uns_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [XLEN-1:0]  dat_o
);

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] mask;
  logic            sgn;

  assign sh = rdt_i >> {off_i, 3'b000};

  always_comb begin
    mask = '1;
    sgn  = 1'b0;
    case (ld_siz_t'(siz_i))
      LD_B: begin mask = XLEN'(8'hFF);          sgn = sh[7];  end
      LD_H: begin mask = XLEN'(16'hFFFF);       sgn = sh[15]; end
      LD_W: begin mask = XLEN'(32'hFFFF_FFFF);  sgn = sh[31]; end
      default: begin mask = '1;                 sgn = 1'b0;   end
    endcase
    // Bits above the access size come from the sign unless zero-extending.
    dat_o = (sh & mask) | ({XLEN{sgn & ~uns_i}} & ~mask);
  end

endmodule

// File: rtl/r5p_wbu.sv
// Write-back unit: arbitrates load responses and ALU results onto the GPR write
// port, tracks one outstanding load and reports read hazards to decode.
// Optional R5P_WBU_FWD_EN adds fwd_vld/fwd_dat forwarding of in-flight results.
module r5p_wbu
  import r5p_pkg::*;
#(
  parameter int AW   = 5,
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_vld,
  input  logic [AW-1:0]             ex_rd,
  input  logic [XLEN-1:0]           ex_dat,
  input  logic                      ld_vld,
  output logic                      ld_rdy,
  input  logic [AW-1:0]             ld_rd,
  input  logic [1:0]                ld_siz,
  input  logic                      ld_uns,
  input  logic [$clog2(XLEN/8)-1:0] ld_off,
  input  logic                      rsp_vld,
  input  logic [XLEN-1:0]           rsp_rdt,
  output logic                      stall,
  input  logic [AW-1:0]             hz_a,
  output logic                      hz,
`ifdef R5P_WBU_FWD_EN
  output logic                      fwd_vld,
  output logic [XLEN-1:0]           fwd_dat,
`endif
  output logic                      e_rd,
  output logic [AW-1:0]             a_rd,
  output logic [XLEN-1:0]           d_rd
);

  logic            pend_q, pend_d;
  ld_pend_t        ld_q, ld_d;
  logic            kill_q, kill_d;
  logic            buf_vld_q, buf_vld_d;
  logic [AW-1:0]   buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_dat_q, buf_dat_d;
  logic            e_rd_q, e_rd_d;
  logic [AW-1:0]   a_rd_q, a_rd_d;
  logic [XLEN-1:0] d_rd_q, d_rd_d;

  logic [XLEN-1:0] ld_dat;
  logic [AW-1:0]   ld_rd_p;
  logic            rsp_acc, ex_ok, ld_acc;

  r5p_wbu_lda #(.XLEN(XLEN)) u_lda (
    .rdt_i (rsp_rdt),
    .siz_i (ld_q.siz),
    .uns_i (ld_q.uns),
    .off_i (ld_q.off),
    .dat_o (ld_dat)
  );

  assign ld_rd_p = ld_q.rd[AW-1:0];
  assign rsp_acc = rsp_vld & pend_q;
  assign ex_ok   = ex_vld & (ex_rd != '0);
  assign ld_rdy  = ~pend_q | rsp_vld;
  assign ld_acc  = ld_vld & ld_rdy;

  always_comb begin
    pend_d    = pend_q;
    ld_d      = ld_q;
    kill_d    = kill_q;
    buf_vld_d = buf_vld_q;
    buf_rd_d  = buf_rd_q;
    buf_dat_d = buf_dat_q;
    e_rd_d    = 1'b0;
    a_rd_d    = a_rd_q;
    d_rd_d    = d_rd_q;

    if (rsp_acc) begin
      pend_d = 1'b0;
      kill_d = 1'b0;
      if (!kill_q && (ld_rd_p != '0)) begin
        e_rd_d = 1'b1;
        a_rd_d = ld_rd_p;
        d_rd_d = ld_dat;
      end
      if (ex_ok) begin
        buf_vld_d = 1'b1;
        buf_rd_d  = ex_rd;
        buf_dat_d = ex_dat;
      end
    end else if (buf_vld_q) begin
      e_rd_d    = 1'b1;
      a_rd_d    = buf_rd_q;
      d_rd_d    = buf_dat_q;
      buf_vld_d = 1'b0;
    end else if (ex_ok) begin
      e_rd_d = 1'b1;
      a_rd_d = ex_rd;
      d_rd_d = ex_dat;
    end

    // A younger ALU write to the load's target makes the load result stale.
    if (pend_q && !rsp_acc && ex_ok && (ex_rd == ld_rd_p)) kill_d = 1'b1;

    if (ld_acc) begin
      pend_d     = 1'b1;
      kill_d     = 1'b0;
      ld_d.rd    = RD_W'(ld_rd);
      ld_d.siz   = ld_siz_t'(ld_siz);
      ld_d.uns   = ld_uns;
      ld_d.off   = OFF_W'(ld_off);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 1'b0;
      ld_q      <= '0;
      kill_q    <= 1'b0;
      buf_vld_q <= 1'b0;
      buf_rd_q  <= '0;
      buf_dat_q <= '0;
      e_rd_q    <= 1'b0;
      a_rd_q    <= '0;
      d_rd_q    <= '0;
    end else begin
      pend_q    <= pend_d;
      ld_q      <= ld_d;
      kill_q    <= kill_d;
      buf_vld_q <= buf_vld_d;
      buf_rd_q  <= buf_rd_d;
      buf_dat_q <= buf_dat_d;
      e_rd_q    <= e_rd_d;
      a_rd_q    <= a_rd_d;
      d_rd_q    <= d_rd_d;
    end
  end

  assign stall = buf_vld_q;
  assign e_rd  = e_rd_q;
  assign a_rd  = a_rd_q;
  assign d_rd  = d_rd_q;

  logic hz_nz, m_ld, m_wp, m_bf;
  assign hz_nz = (hz_a != '0);
  assign m_ld  = pend_q & ~kill_q & (ld_rd_p == hz_a);
  assign m_wp  = e_rd_q & (a_rd_q == hz_a);
  assign m_bf  = buf_vld_q & (buf_rd_q == hz_a);

`ifdef R5P_WBU_FWD_EN
  // The buffered entry is younger than the write port, so it wins.
  assign hz      = hz_nz & m_ld;
  assign fwd_vld = hz_nz & (m_bf | m_wp);
  assign fwd_dat = m_bf ? buf_dat_q : d_rd_q;
`else
  assign hz      = hz_nz & (m_ld | m_wp | m_bf);
`endif

`ifndef SYNTHESIS
  // A response may still arrive for a load that was discarded by reset.
  logic disc_q;
  always_ff @(posedge clk) begin
    if (rst)                    disc_q <= disc_q | pend_q;
    else if (rsp_vld || ld_vld) disc_q <= 1'b0;
  end

  a_ex_stall: assert property (@(posedge clk) disable iff (rst) !(ex_vld && stall));
  a_ld_rdy:   assert property (@(posedge clk) disable iff (rst) !(ld_vld && !ld_rdy));
  a_rsp_pend: assert property (@(posedge clk) disable iff (rst) !(rsp_vld && !pend_q && !disc_q));
`endif

endmodule

// File: tb/tb_r5p_wbu.sv
// Self-checking bench for r5p_wbu: directed scenarios then randomized traffic,
// checked against a transaction-level model. Honours R5P_WBU_FWD_EN.
module tb_r5p_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_vld;
  logic [4:0]  ex_rd;
  logic [31:0] ex_dat;
  logic        ld_vld;
  logic        ld_rdy;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_siz;
  logic        ld_uns;
  logic [1:0]  ld_off;
  logic        rsp_vld;
  logic [31:0] rsp_rdt;
  logic        stall;
  logic [4:0]  hz_a;
  logic        hz;
  logic        e_rd;
  logic [4:0]  a_rd;
  logic [31:0] d_rd;
`ifdef R5P_WBU_FWD_EN
  logic        fwd_vld;
  logic [31:0] fwd_dat;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  r5p_wbu dut (
    .clk(clk), .rst(rst),
    .ex_vld(ex_vld), .ex_rd(ex_rd), .ex_dat(ex_dat),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_rd(ld_rd), .ld_siz(ld_siz),
    .ld_uns(ld_uns), .ld_off(ld_off),
    .rsp_vld(rsp_vld), .rsp_rdt(rsp_rdt),
    .stall(stall), .hz_a(hz_a), .hz(hz),
`ifdef R5P_WBU_FWD_EN
    .fwd_vld(fwd_vld), .fwd_dat(fwd_dat),
`endif
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd)
  );

  // Transaction-level reference model.
  typedef struct { logic [4:0] rd; logic [31:0] dat; } ent_t;
  ent_t        bufq[$];
  bit          m_pend, m_kill;
  logic [4:0]  m_rd;
  int          m_siz, m_off;
  bit          m_uns;
  bit          m_wr_en;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_dat;

  function automatic logic [31:0] ld_val(logic [31:0] rdt, int siz, bit uns, int off);
    longint unsigned v = 64'(rdt) >> (8 * off);
    int nb = (siz == 0) ? 1 : (siz == 1) ? 2 : 4;
    longint unsigned m = 64'd1 << (8 * nb);
    v = v % m;
    if (!uns && v >= m / 2) v = v + (64'd1 << 32) - m;
    return v[31:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_hz();
    if (hz_a == 0) return 1'b0;
    if (m_pend && !m_kill && m_rd == hz_a) return 1'b1;
`ifndef R5P_WBU_FWD_EN
    if (m_wr_en && m_wr_rd == hz_a) return 1'b1;
    if (bufq.size() > 0 && bufq[0].rd == hz_a) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_step();
    bit taken;
    bit nw_en;
    logic [4:0] nw_rd;
    logic [31:0] nw_dat;
    ent_t e;
    if (rst) begin
      m_pend = 0; m_kill = 0; bufq.delete();
      m_wr_en = 0; m_wr_rd = 0; m_wr_dat = 0;
      return;
    end
    nw_en = 0; nw_rd = m_wr_rd; nw_dat = m_wr_dat;
    taken = rsp_vld && m_pend;
    if (taken) begin
      if (!m_kill && m_rd != 0) begin
        nw_en = 1; nw_rd = m_rd; nw_dat = ld_val(rsp_rdt, m_siz, m_uns, m_off);
      end
      if (ex_vld && ex_rd != 0) bufq.push_back('{ex_rd, ex_dat});
    end else if (bufq.size() > 0) begin
      e = bufq.pop_front();
      nw_en = 1; nw_rd = e.rd; nw_dat = e.dat;
    end else if (ex_vld && ex_rd != 0) begin
      nw_en = 1; nw_rd = ex_rd; nw_dat = ex_dat;
    end
    if (m_pend && !taken && ex_vld && ex_rd != 0 && ex_rd == m_rd) m_kill = 1;
    if (taken) begin m_pend = 0; m_kill = 0; end
    if (ld_vld) begin
      m_pend = 1; m_kill = 0; m_rd = ld_rd;
      m_siz = int'(ld_siz); m_uns = ld_uns; m_off = int'(ld_off);
    end
    m_wr_en = nw_en; m_wr_rd = nw_rd; m_wr_dat = nw_dat;
  endtask

  // One clock: combinational checks with current inputs, then registered checks.
  task automatic cyc();
    #1;
    chk("ld_rdy", 64'(ld_rdy), 64'(!m_pend || rsp_vld));
    chk("stall", 64'(stall), 64'(bufq.size() > 0));
    chk("hz", 64'(hz), 64'(exp_hz()));
`ifdef R5P_WBU_FWD_EN
    begin
      bit bm, wm;
      bm = (hz_a != 0) && bufq.size() > 0 && bufq[0].rd == hz_a;
      wm = (hz_a != 0) && m_wr_en && m_wr_rd == hz_a;
      chk("fwd_vld", 64'(fwd_vld), 64'(bm || wm));
      if (bm) chk("fwd_dat", 64'(fwd_dat), 64'(bufq[0].dat));
      else if (wm) chk("fwd_dat", 64'(fwd_dat), 64'(m_wr_dat));
    end
`endif
    model_step();
    @(posedge clk);
    #1;
    chk("e_rd", 64'(e_rd), 64'(m_wr_en));
    if (m_wr_en) begin
      chk("a_rd", 64'(a_rd), 64'(m_wr_rd));
      chk("d_rd", 64'(d_rd), 64'(m_wr_dat));
    end
  endtask

  task automatic idle();
    rst = 0; ex_vld = 0; ld_vld = 0; rsp_vld = 0;
  endtask

  task automatic do_load(logic [4:0] rd, logic [1:0] siz, bit uns, logic [1:0] off,
                         logic [31:0] rdt);
    idle(); ld_vld = 1; ld_rd = rd; ld_siz = siz; ld_uns = uns; ld_off = off;
    cyc();
    idle(); rsp_vld = 1; rsp_rdt = rdt;
    cyc();
    idle();
  endtask

  initial begin
    rst = 1; ex_vld = 0; ex_rd = 0; ex_dat = 0; ld_vld = 0; ld_rd = 0; ld_siz = 0;
    ld_uns = 0; ld_off = 0; rsp_vld = 0; rsp_rdt = 0; hz_a = 0;
    m_pend = 0; m_kill = 0; m_rd = 0; m_siz = 0; m_off = 0; m_uns = 0;
    m_wr_en = 0; m_wr_rd = 0; m_wr_dat = 0;
    cyc(); cyc();
    idle();
    #1;
    chk("rst_e_rd", 64'(e_rd), 64'd0);
    chk("rst_a_rd", 64'(a_rd), 64'd0);
    chk("rst_d_rd", 64'(d_rd), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hz", 64'(hz), 64'd0);
    chk("rst_ld_rdy", 64'(ld_rdy), 64'd1);
    $display("txn reset done");

    // ALU write
    ex_vld = 1; ex_rd = 5; ex_dat = 32'h1234;
    cyc();
    chk("t1_a_rd", 64'(a_rd), 64'd5);
    chk("t1_d_rd", 64'(d_rd), 64'h1234);
    $display("txn alu rd=5 -> e_rd=%0d a_rd=%0d d_rd=%h", e_rd, a_rd, d_rd);
    idle();

    // Load alignment and extension
    do_load(7, 2'd0, 0, 2'd3, 32'h80AABBCC);
    chk("t2_lb", 64'(d_rd), 64'hFFFFFF80);
    $display("txn lb off=3 -> d_rd=%h", d_rd);
    do_load(7, 2'd0, 1, 2'd3, 32'h80AABBCC);
    chk("t2_lbu", 64'(d_rd), 64'h00000080);
    $display("txn lbu off=3 -> d_rd=%h", d_rd);
    do_load(7, 2'd1, 0, 2'd2, 32'h80AABBCC);
    chk("t2_lh", 64'(d_rd), 64'hFFFF80AA);
    $display("txn lh off=2 -> d_rd=%h", d_rd);

    // Response and ALU collide: ALU buffered one cycle
    ld_vld = 1; ld_rd = 7; ld_siz = 2; ld_uns = 0; ld_off = 0;
    cyc();
    idle(); rsp_vld = 1; rsp_rdt = 32'hCAFE0001; ex_vld = 1; ex_rd = 3; ex_dat = 32'h33;
    cyc();
    chk("t3_ld_a_rd", 64'(a_rd), 64'd7);
    chk("t3_stall1", 64'(stall), 64'd1);
    idle();
    cyc();
    chk("t3_alu_a_rd", 64'(a_rd), 64'd3);
    chk("t3_alu_d_rd", 64'(d_rd), 64'h33);
    chk("t3_stall0", 64'(stall), 64'd0);
    $display("txn collide -> a_rd=%0d d_rd=%h stall=%0d", a_rd, d_rd, stall);

    // Pending-load hazard and WAW kill
    ld_vld = 1; ld_rd = 9; ld_siz = 2; ld_uns = 0; ld_off = 0; hz_a = 9;
    cyc();
    idle();
    #1;
    chk("t4_hz_pend", 64'(hz), 64'd1);
    cyc();
    ex_vld = 1; ex_rd = 9; ex_dat = 32'h9999;
    cyc();
    chk("t4_alu_d_rd", 64'(d_rd), 64'h9999);
    idle(); rsp_vld = 1; rsp_rdt = 32'hDEADBEEF;
    cyc();
    chk("t4_kill_e_rd", 64'(e_rd), 64'd0);
    $display("txn waw kill -> e_rd=%0d", e_rd);
    idle(); hz_a = 0;

    // rd=0 dropped; reset discards a pending load
    ex_vld = 1; ex_rd = 0; ex_dat = 32'hFFFF;
    cyc();
    chk("t5_rd0", 64'(e_rd), 64'd0);
    idle(); ld_vld = 1; ld_rd = 6; ld_siz = 2;
    cyc();
    idle(); rst = 1;
    cyc();
    idle();
    #1;
    chk("t5_ld_rdy", 64'(ld_rdy), 64'd1);
    rsp_vld = 1; rsp_rdt = 32'h12345678;
    cyc();
    chk("t5_orphan", 64'(e_rd), 64'd0);
    $display("txn reset mid-load -> e_rd=%0d", e_rd);
    idle();

    // Forwarding from the write port
    ex_vld = 1; ex_rd = 4; ex_dat = 32'h55;
    cyc();
    idle(); hz_a = 4;
    #1;
`ifdef R5P_WBU_FWD_EN
    chk("t6_fwd_vld", 64'(fwd_vld), 64'd1);
    chk("t6_fwd_dat", 64'(fwd_dat), 64'h55);
    chk("t6_hz", 64'(hz), 64'd0);
`else
    chk("t6_hz", 64'(hz), 64'd1);
`endif
    $display("txn hazard on write port rd=4 -> hz=%0d", hz);
    cyc();
    hz_a = 0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      ex_vld  = (bufq.size() == 0) && ($urandom_range(0, 1) == 1);
      ex_rd   = 5'($urandom_range(0, 7));
      ex_dat  = $urandom();
      rsp_vld = m_pend && ($urandom_range(0, 2) == 0);
      rsp_rdt = $urandom();
      ld_vld  = (!m_pend || rsp_vld) && ($urandom_range(0, 2) == 0);
      ld_rd   = 5'($urandom_range(0, 7));
      ld_siz  = 2'($urandom_range(0, 2));
      ld_uns  = 1'($urandom_range(0, 1));
      ld_off  = 2'($urandom_range(0, 3));
      hz_a    = 5'($urandom_range(0, 7));
      cyc();
      if (e_rd) $display("txn rnd %0d write a_rd=%0d d_rd=%h", i, a_rd, d_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
